// File: rtl/decode_queue.sv
// decode_queue: RV32IM decode of up to WIDTH fetch lanes per cycle into an in-order circular queue.
// Build option DECQ_ILLEGAL_FENCE_EN: stop accepting behind an enqueued illegal/halt entry until it leaves.
`timescale 1ns/1ps
module decode_queue #(
   parameter int WIDTH = 2,
   parameter int DEPTH = 8,
   localparam int FP_W  = 64,
   localparam int DP_W  = 120,
   localparam int REG_W = 5,
   localparam int CW    = $clog2(WIDTH + 1),
   localparam int NW    = $clog2(DEPTH + 1),
   localparam int AW    = (DEPTH > 1) ? $clog2(DEPTH) : 1
) (
   input  logic                    clock,
   input  logic                    reset_n,
   input  logic [WIDTH-1:0]        fetch_valid,
   input  logic [WIDTH*FP_W-1:0]   fetch_packets,
   output logic [CW-1:0]           fetch_accept_count,
   input  logic [CW-1:0]           dispatch_count,
   input  logic                    squash,
   output logic [WIDTH*DP_W-1:0]   decode_out,
   output logic [WIDTH-1:0]        decode_out_valid,
   output logic [WIDTH-1:0]        rs1_used,
   output logic [WIDTH-1:0]        rs2_used,
   output logic [WIDTH*REG_W-1:0]  src1_reg,
   output logic [WIDTH*REG_W-1:0]  src2_reg,
   output logic [WIDTH*REG_W-1:0]  dest_reg,
   output logic [NW-1:0]           entry_count
);

   localparam logic [1:0] OPA_RS1  = 2'd0;
   localparam logic [1:0] OPA_PC   = 2'd2;
   localparam logic [1:0] OPA_ZERO = 2'd3;
   localparam logic [2:0] OPB_RS2  = 3'd0;
   localparam logic [2:0] OPB_I    = 3'd1;
   localparam logic [2:0] OPB_S    = 3'd2;
   localparam logic [2:0] OPB_B    = 3'd3;
   localparam logic [2:0] OPB_U    = 3'd4;
   localparam logic [2:0] OPB_J    = 3'd5;
   localparam logic [3:0] ALU_ADD  = 4'd0;
   localparam logic [3:0] ALU_SUB  = 4'd1;
   localparam logic [3:0] ALU_SLT  = 4'd2;
   localparam logic [3:0] ALU_SLTU = 4'd3;
   localparam logic [3:0] ALU_AND  = 4'd4;
   localparam logic [3:0] ALU_OR   = 4'd5;
   localparam logic [3:0] ALU_XOR  = 4'd6;
   localparam logic [3:0] ALU_SLL  = 4'd7;
   localparam logic [3:0] ALU_SRL  = 4'd8;
   localparam logic [3:0] ALU_SRA  = 4'd9;
   localparam logic [1:0] FU_ALU   = 2'd0;
   localparam logic [1:0] FU_LDST  = 2'd1;
   localparam logic [1:0] FU_MULT  = 2'd2;
   localparam logic [1:0] FU_BU    = 2'd3;

   // Packet, MSB first: pc, npc, inst, opa, opb, alu_func, mult_func, fu_type,
   // has_dest, mult, rd_mem, wr_mem, cond_br, uncond_br, csr_op, halt, illegal, valid.
   function automatic logic [DP_W-1:0] decode_lane(input logic [FP_W-1:0] fp);
      logic [31:0] pc, inst, npc;
      logic [6:0]  opcode, funct7;
      logic [2:0]  funct3, opb;
      logic [1:0]  opa, fu;
      logic [3:0]  alu;
      logic        has_dest, mult, rd_mem, wr_mem, cond_br, uncond_br, csr_op, halt, illegal;
      pc        = fp[63:32];
      inst      = fp[31:0];
      npc       = pc + 32'd4;
      opcode    = inst[6:0];
      funct3    = inst[14:12];
      funct7    = inst[31:25];
      opa       = OPA_RS1;
      opb       = OPB_RS2;
      alu       = ALU_ADD;
      has_dest  = 1'b0;
      mult      = 1'b0;
      rd_mem    = 1'b0;
      wr_mem    = 1'b0;
      cond_br   = 1'b0;
      uncond_br = 1'b0;
      csr_op    = 1'b0;
      halt      = 1'b0;
      illegal   = 1'b0;
      case (opcode)
         7'b0110111: begin opa = OPA_ZERO; opb = OPB_U; has_dest = 1'b1; end
         7'b0010111: begin opa = OPA_PC; opb = OPB_U; has_dest = 1'b1; end
         7'b1101111: begin opa = OPA_PC; opb = OPB_J; has_dest = 1'b1; uncond_br = 1'b1; end
         7'b1100111: begin
            opb       = OPB_I;
            has_dest  = 1'b1;
            uncond_br = 1'b1;
            illegal   = (funct3 != 3'b000);
         end
         7'b1100011: begin
            opa     = OPA_PC;
            opb     = OPB_B;
            cond_br = 1'b1;
            illegal = (funct3 == 3'b010) || (funct3 == 3'b011);
         end
         7'b0000011: begin
            opb      = OPB_I;
            has_dest = 1'b1;
            rd_mem   = 1'b1;
            illegal  = (funct3 == 3'b011) || (funct3 == 3'b110) || (funct3 == 3'b111);
         end
         7'b0100011: begin
            opb     = OPB_S;
            wr_mem  = 1'b1;
            illegal = funct3[2] || (funct3 == 3'b011);
         end
         7'b0010011: begin
            opb      = OPB_I;
            has_dest = 1'b1;
            case (funct3)
               3'b000:  alu = ALU_ADD;
               3'b010:  alu = ALU_SLT;
               3'b011:  alu = ALU_SLTU;
               3'b100:  alu = ALU_XOR;
               3'b110:  alu = ALU_OR;
               3'b111:  alu = ALU_AND;
               3'b001:  begin alu = ALU_SLL; illegal = (funct7 != 7'b0000000); end
               3'b101:  begin
                  alu     = funct7[5] ? ALU_SRA : ALU_SRL;
                  illegal = (funct7 != 7'b0000000) && (funct7 != 7'b0100000);
               end
               default: illegal = 1'b1;
            endcase
         end
         7'b0110011: begin
            has_dest = 1'b1;
            if (funct7 == 7'b0000001) begin
               mult = 1'b1;
            end else if (funct7 == 7'b0000000) begin
               case (funct3)
                  3'b000:  alu = ALU_ADD;
                  3'b001:  alu = ALU_SLL;
                  3'b010:  alu = ALU_SLT;
                  3'b011:  alu = ALU_SLTU;
                  3'b100:  alu = ALU_XOR;
                  3'b101:  alu = ALU_SRL;
                  3'b110:  alu = ALU_OR;
                  3'b111:  alu = ALU_AND;
                  default: illegal = 1'b1;
               endcase
            end else if ((funct7 == 7'b0100000) && (funct3 == 3'b000)) begin
               alu = ALU_SUB;
            end else if ((funct7 == 7'b0100000) && (funct3 == 3'b101)) begin
               alu = ALU_SRA;
            end else begin
               illegal = 1'b1;
            end
         end
         7'b0001111: begin
            has_dest = 1'b0;
         end
         7'b1110011: begin
            if (funct3 == 3'b000) begin
               // WFI is the simulation halt; ECALL/EBREAK are not supported
               halt    = (inst == 32'h10500073);
               illegal = !halt;
            end else begin
               csr_op   = 1'b1;
               has_dest = 1'b1;
               illegal  = (funct3 == 3'b100);
            end
         end
         default: illegal = 1'b1;
      endcase
      if (cond_br || uncond_br) begin
         fu = FU_BU;
      end else if (rd_mem || wr_mem) begin
         fu = FU_LDST;
      end else if (mult) begin
         fu = FU_MULT;
      end else begin
         fu = FU_ALU;
      end
      return {pc, npc, inst, opa, opb, alu, funct3, fu, has_dest, mult, rd_mem, wr_mem,
              cond_br, uncond_br, csr_op, halt, illegal, 1'b1};
   endfunction

   logic [AW-1:0]   head_q, head_d, tail_q, tail_d;
   logic [NW-1:0]   count_q, count_d;
   logic [DP_W-1:0] mem_q [DEPTH];
   logic [DP_W-1:0] dec_s [WIDTH];
   logic [AW-1:0]   wr_idx_s [WIDTH];
   logic [AW-1:0]   rd_idx_s [WIDTH];
   logic [CW-1:0]   accept_s, deq_s;
   logic            fenced_s;
`ifdef DECQ_ILLEGAL_FENCE_EN
   logic            fence_q, fence_d;
   logic [AW-1:0]   fence_idx_q, fence_idx_d;
   logic            fence_set_s;
   logic [AW-1:0]   fence_widx_s;
`endif

   // per-lane decode and wrapped storage indices
   always_comb begin
      for (int i = 0; i < WIDTH; i++) begin
         dec_s[i]    = decode_lane(fetch_packets[i*FP_W +: FP_W]);
         wr_idx_s[i] = AW'((int'(tail_q) + i) % DEPTH);
         rd_idx_s[i] = AW'((int'(head_q) + i) % DEPTH);
      end
   end

   // enqueue count: leading valid run, bounded by free slots and any fence
   always_comb begin
      int  free_v;
      int  k_v;
      logic stop_v;
      free_v = DEPTH - int'(count_q);
      k_v    = 0;
      stop_v = 1'b0;
`ifdef DECQ_ILLEGAL_FENCE_EN
      fence_set_s  = 1'b0;
      fence_widx_s = '0;
`endif
      for (int i = 0; i < WIDTH; i++) begin
         if (!stop_v && fetch_valid[i] && (i < free_v) && !fenced_s) begin
            k_v = i + 1;
`ifdef DECQ_ILLEGAL_FENCE_EN
            if (dec_s[i][2] || dec_s[i][1]) begin
               stop_v       = 1'b1;
               fence_set_s  = 1'b1;
               fence_widx_s = wr_idx_s[i];
            end else begin
               stop_v = 1'b0;
            end
`endif
         end else begin
            stop_v = 1'b1;
         end
      end
      if (!reset_n || squash) begin
         k_v = 0;
      end else begin
         k_v = k_v;
      end
      accept_s = CW'(k_v);
   end

   assign fetch_accept_count = accept_s;

   // effective dequeue: dispatch request clipped to occupancy and lane count
   always_comb begin
      int d_v;
      d_v = int'(dispatch_count);
      if (d_v > int'(count_q)) begin
         d_v = int'(count_q);
      end else begin
         d_v = d_v;
      end
      if (d_v > WIDTH) begin
         d_v = WIDTH;
      end else begin
         d_v = d_v;
      end
      deq_s = CW'(d_v);
   end

   // pointer and occupancy next state
   always_comb begin
      if (squash) begin
         head_d  = '0;
         tail_d  = '0;
         count_d = '0;
      end else begin
         head_d  = AW'((int'(head_q) + int'(deq_s)) % DEPTH);
         tail_d  = AW'((int'(tail_q) + int'(accept_s)) % DEPTH);
         count_d = NW'(int'(count_q) + int'(accept_s) - int'(deq_s));
      end
   end

   // pointer and occupancy registers
   always_ff @(posedge clock or negedge reset_n) begin
      if (!reset_n) begin
         head_q  <= '0;
         tail_q  <= '0;
         count_q <= '0;
      end else begin
         head_q  <= head_d;
         tail_q  <= tail_d;
         count_q <= count_d;
      end
   end

   // entry storage; squash only clears the valid bits
   always_ff @(posedge clock or negedge reset_n) begin
      if (!reset_n) begin
         for (int e = 0; e < DEPTH; e++) mem_q[e] <= '0;
      end else if (squash) begin
         for (int e = 0; e < DEPTH; e++) mem_q[e][0] <= 1'b0;
      end else begin
         for (int i = 0; i < WIDTH; i++) begin
            if (i < int'(accept_s)) mem_q[wr_idx_s[i]] <= dec_s[i];
         end
      end
   end

`ifdef DECQ_ILLEGAL_FENCE_EN
   assign fenced_s = fence_q;

   // fence tracks the fencing entry's slot until it is dispatched
   always_comb begin
      fence_d     = fence_q;
      fence_idx_d = fence_idx_q;
      for (int j = 0; j < WIDTH; j++) begin
         if (fence_q && (j < int'(deq_s)) && (rd_idx_s[j] == fence_idx_q)) begin
            fence_d = 1'b0;
         end else begin
            fence_d = fence_d;
         end
      end
      if (fence_set_s && (accept_s != '0)) begin
         fence_d     = 1'b1;
         fence_idx_d = fence_widx_s;
      end else begin
         fence_idx_d = fence_idx_d;
      end
      if (squash) begin
         fence_d = 1'b0;
      end else begin
         fence_d = fence_d;
      end
   end

   // fence registers
   always_ff @(posedge clock or negedge reset_n) begin
      if (!reset_n) begin
         fence_q     <= 1'b0;
         fence_idx_q <= '0;
      end else begin
         fence_q     <= fence_d;
         fence_idx_q <= fence_idx_d;
      end
   end
`else
   assign fenced_s = 1'b0;
`endif

   // head window: lanes beyond occupancy read as zero
   always_comb begin
      logic [DP_W-1:0] pkt;
      decode_out       = '0;
      decode_out_valid = '0;
      rs1_used         = '0;
      rs2_used         = '0;
      src1_reg         = '0;
      src2_reg         = '0;
      dest_reg         = '0;
      pkt              = '0;
      for (int i = 0; i < WIDTH; i++) begin
         if (i < int'(count_q)) begin
            pkt                          = mem_q[rd_idx_s[i]];
            decode_out_valid[i]          = 1'b1;
            decode_out[i*DP_W +: DP_W]   = pkt;
            rs1_used[i]                  = pkt[5] || (pkt[23:22] == OPA_RS1);
            rs2_used[i]                  = pkt[5] || pkt[6] || (pkt[21:19] == OPB_RS2);
            src1_reg[i*REG_W +: REG_W]   = pkt[43:39];
            src2_reg[i*REG_W +: REG_W]   = pkt[48:44];
            dest_reg[i*REG_W +: REG_W]   = pkt[35:31];
         end else begin
            pkt = '0;
         end
      end
   end

   assign entry_count = count_q;

endmodule

// File: tb/tb_decode_queue.sv
// Scoreboard bench for decode_queue (WIDTH=2, DEPTH=8); follows DECQ_ILLEGAL_FENCE_EN if defined.
`timescale 1ns/1ps
module tb_decode_queue;
   localparam int DP_W = 120;

   logic         clock = 1'b0;
   logic         reset_n;
   logic [1:0]   fetch_valid;
   logic [127:0] fetch_packets;
   logic [1:0]   fetch_accept_count;
   logic [1:0]   dispatch_count;
   logic         squash;
   logic [239:0] decode_out;
   logic [1:0]   decode_out_valid, rs1_used, rs2_used;
   logic [9:0]   src1_reg, src2_reg, dest_reg;
   logic [3:0]   entry_count;

   typedef struct {
      logic [31:0] pc;
      logic [31:0] inst;
      logic        fencer;
   } sb_t;
   sb_t sb[$];

   int n_cmp = 0;
   int n_err = 0;

   localparam logic [31:0] ADDI = 32'h00500093;
   localparam logic [31:0] MUL  = 32'h022081B3;
   localparam logic [31:0] BEQ  = 32'h00208463;
   localparam logic [31:0] ILL  = 32'h00000000;

   decode_queue #(.WIDTH(2), .DEPTH(8)) dut (
      .clock(clock), .reset_n(reset_n), .fetch_valid(fetch_valid),
      .fetch_packets(fetch_packets), .fetch_accept_count(fetch_accept_count),
      .dispatch_count(dispatch_count), .squash(squash), .decode_out(decode_out),
      .decode_out_valid(decode_out_valid), .rs1_used(rs1_used), .rs2_used(rs2_used),
      .src1_reg(src1_reg), .src2_reg(src2_reg), .dest_reg(dest_reg),
      .entry_count(entry_count)
   );

   always #5 clock = ~clock;

   task automatic chk(input string tag, input logic [127:0] got, input logic [127:0] exp);
      n_cmp++;
      if (got !== exp) begin
         n_err++;
         $display("FAIL %s: got %0h expected %0h", tag, got, exp);
      end
   endtask

   function automatic logic [31:0] mk_add(input int n);
      logic [4:0] rd;
      rd = 5'(n);
      return {7'd0, 5'd2, 5'd1, 3'd0, rd, 7'b0110011};
   endfunction

   function automatic int exp_accept(input logic [1:0] fv, input logic f0, input logic sq);
      int k;
      int free_n;
      k = 0;
      free_n = 8 - sb.size();
      if (sq) return 0;
`ifdef DECQ_ILLEGAL_FENCE_EN
      foreach (sb[j]) if (sb[j].fencer) return 0;
`endif
      if (fv[0] && free_n >= 1) begin
         k = 1;
`ifdef DECQ_ILLEGAL_FENCE_EN
         if (f0) return 1;
`endif
         if (fv[1] && free_n >= 2) k = 2;
      end
      return k;
   endfunction

   task automatic step(input logic [1:0] fv,
                       input logic [31:0] pc0, input logic [31:0] in0, input logic f0,
                       input logic [31:0] pc1, input logic [31:0] in1, input logic f1,
                       input logic [1:0] dc, input logic sq);
      int k, d, sz;
      logic [DP_W-1:0] lane;
      @(negedge clock);
      fetch_valid    = fv;
      fetch_packets  = {pc1, in1, pc0, in0};
      dispatch_count = dc;
      squash         = sq;
      #1;
      sz = sb.size();
      k  = exp_accept(fv, f0, sq);
      chk("accept", {126'd0, fetch_accept_count}, 128'(k));
      chk("count", {124'd0, entry_count}, 128'(sz));
      chk("out_valid", {126'd0, decode_out_valid},
          (sz >= 2) ? 128'd3 : ((sz == 1) ? 128'd1 : 128'd0));
      for (int i = 0; i < 2; i++) begin
         lane = decode_out[i*DP_W +: DP_W];
         if (i < sz) begin
            chk("lane_pc", {96'd0, lane[119:88]}, {96'd0, sb[i].pc});
            chk("lane_npc", {96'd0, lane[87:56]}, {96'd0, sb[i].pc + 32'd4});
            chk("lane_inst", {96'd0, lane[55:24]}, {96'd0, sb[i].inst});
            chk("lane_vbit", {127'd0, lane[0]}, 128'd1);
         end else begin
            chk("lane_zero", {8'd0, lane}, 128'd0);
         end
      end
      d = int'(dc);
      if (d > sz) d = sz;
      if (d > 2) d = 2;
      @(posedge clock);
      if (sq) begin
         sb.delete();
      end else begin
         repeat (d) void'(sb.pop_front());
         if (k >= 1) sb.push_back('{pc0, in0, f0});
         if (k >= 2) sb.push_back('{pc1, in1, f1});
      end
   endtask

   initial begin
      logic [31:0] pc;
      reset_n        = 1'b0;
      fetch_valid    = 2'b11;
      fetch_packets  = {32'h4, MUL, 32'h0, ADDI};
      dispatch_count = 2'd0;
      squash         = 1'b0;
      #1;
      chk("rst_accept", {126'd0, fetch_accept_count}, 128'd0);
      chk("rst_valid", {126'd0, decode_out_valid}, 128'd0);
      chk("rst_count", {124'd0, entry_count}, 128'd0);
      chk("rst_dout", {127'd0, |decode_out}, 128'd0);
      fetch_valid = 2'b00;
      repeat (2) @(negedge clock);
      reset_n = 1'b1;

      step(2'b11, 32'h0, ADDI, 1'b0, 32'h4, MUL, 1'b0, 2'd0, 1'b0);
      #2;
      chk("addi_fu", {126'd0, decode_out[11:10]}, 128'd0);
      chk("addi_opb", {125'd0, decode_out[21:19]}, 128'd1);
      chk("addi_rs1u", {127'd0, rs1_used[0]}, 128'd1);
      chk("addi_rs2u", {127'd0, rs2_used[0]}, 128'd0);
      chk("mul_mult", {127'd0, decode_out[DP_W+8]}, 128'd1);
      chk("mul_fu", {126'd0, decode_out[DP_W+11 -: 2]}, 128'd2);
      chk("mul_regs", {113'd0, dest_reg[9:5], src1_reg[9:5], src2_reg[9:5]},
          {113'd0, 5'd3, 5'd1, 5'd2});

      step(2'b10, 32'h8, ADDI, 1'b0, 32'hC, ADDI, 1'b0, 2'd0, 1'b0);
      step(2'b01, 32'h10, BEQ, 1'b0, 32'h14, ADDI, 1'b0, 2'd2, 1'b0);
      #2;
      chk("beq_rs1u", {127'd0, rs1_used[0]}, 128'd1);
      chk("beq_rs2u", {127'd0, rs2_used[0]}, 128'd1);
      chk("beq_fu", {126'd0, decode_out[11:10]}, 128'd3);

      pc = 32'h100;
      for (int r = 0; r < 4; r++) begin
         step(2'b11, pc, mk_add(r * 2), 1'b0, pc + 32'd4, mk_add(r * 2 + 1), 1'b0, 2'd0, 1'b0);
         pc = pc + 32'd8;
      end
      step(2'b11, pc, ADDI, 1'b0, pc + 32'd4, ADDI, 1'b0, 2'd2, 1'b0);
      #2;
      chk("full_drain_count", {124'd0, entry_count}, 128'd6);
      for (int r = 0; r < 20; r++) begin
         step(2'b11, pc, mk_add(r), 1'b0, pc + 32'd4, mk_add(r + 7), 1'b0, 2'd2, 1'b0);
         pc = pc + 32'd8;
      end
      step(2'b00, pc, ADDI, 1'b0, pc, ADDI, 1'b0, 2'd1, 1'b0);
      #2;
      chk("pre_squash_count", {124'd0, entry_count}, 128'd5);
      step(2'b11, pc, ADDI, 1'b0, pc + 32'd4, ADDI, 1'b0, 2'd2, 1'b1);
      #2;
      chk("squash_count", {124'd0, entry_count}, 128'd0);
      chk("squash_valid", {126'd0, decode_out_valid}, 128'd0);

      step(2'b11, 32'h200, ADDI, 1'b0, 32'h204, MUL, 1'b0, 2'd0, 1'b0);
      #3;
      reset_n = 1'b0;
      #1;
      chk("mid_rst_valid", {126'd0, decode_out_valid}, 128'd0);
      chk("mid_rst_count", {124'd0, entry_count}, 128'd0);
      chk("mid_rst_dout", {127'd0, |decode_out}, 128'd0);
      chk("mid_rst_accept", {126'd0, fetch_accept_count}, 128'd0);
      sb.delete();
      fetch_valid = 2'b00;
      @(negedge clock);
      reset_n = 1'b1;

      for (int r = 0; r < 3; r++)
         step(2'b11, 32'h300 + 32'(r * 8), ILL, 1'b1, 32'h304 + 32'(r * 8), 32'h002082B3, 1'b0,
              2'd0, 1'b0);
      step(2'b11, 32'h400, ADDI, 1'b0, 32'h404, ADDI, 1'b0, 2'd1, 1'b0);
      step(2'b11, 32'h408, ADDI, 1'b0, 32'h40C, ADDI, 1'b0, 2'd0, 1'b0);
      for (int r = 0; r < 6; r++)
         step(2'b00, 32'h0, ADDI, 1'b0, 32'h0, ADDI, 1'b0, 2'd3, 1'b0);
      #2;
      chk("drain_empty", {124'd0, entry_count}, 128'd0);

      $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_err);
      $finish;
   end
endmodule

// File: doc/decode_queue.md
# decode_queue

Superscalar decode stage sitting between the instruction buffer and dispatch. Each cycle it decodes up to `WIDTH` fetch packets in parallel into `DECODE_PACKET`s, plus register-usage and arch-register fields, and stores them in an in-order circular queue of `DEPTH` entries. Dispatch drains the queue from the head, up to `WIDTH` per cycle. This decouples fetch bandwidth from rename/dispatch stalls and provides a single squash point for the front end.

## Interface
Parameters:
- `WIDTH`, 2: decode/enqueue lanes and max dequeue per cycle; 1..4.
- `DEPTH`, 8: queue entries; power of two, ≥ `WIDTH`.

Ports:
- `clock`  in  1  Sole clock; all state updates on posedge.
- `reset_n`  in  1  Asynchronous, active-low reset.
- `fetch_valid`  in  `WIDTH`  Per-lane valid. Only the contiguous prefix starting at lane 0 is considered.
- `fetch_packets`  in  `WIDTH` x `FETCH_PACKET`  Lane i carries the i-th oldest instruction.
- `fetch_accept_count`  out  `$clog2(WIDTH+1)`  Number of lanes enqueued this cycle (combinational).
- `dispatch_count`  in  `$clog2(WIDTH+1)`  Number of head entries consumed this cycle.
- `squash`  in  1  Flush all entries; has priority over everything except reset.
- `decode_out`  out  `WIDTH` x `DECODE_PACKET`  Head entries; lane 0 is the oldest.
- `decode_out_valid`  out  `WIDTH`  Thermometer mask, `min(count, WIDTH)` ones.
- `rs1_used`, `rs2_used`  out  `WIDTH` each  Per-entry source-usage flags.
- `src1_reg`, `src2_reg`, `dest_reg`  out  `WIDTH` x `ARCH_REG_IDX`  Taken from rs1, rs2 and rd.
- `entry_count`  out  `$clog2(DEPTH+1)`  Registered occupancy.

## Operation
- Per-lane decode is combinational and follows the RV32IM rules:
  - Fields produced: opa/opb select, `alu_func`, `has_dest`, `mult`, `rd_mem`, `wr_mem`, `cond_branch`, `uncond_branch`, `csr_op`, `halt`, `illegal`.
  - `mult_func` = funct3.
  - `NPC` = `PC` + 4, modulo 2^32.
  - `FU_type` = BU if any branch, else LDST if any mem access, else MULT if `mult`, else ALU.
  - `rs1_used` = cond_branch | (opa == RS1).
  - `rs2_used` = cond_branch | wr_mem | (opb == RS2).
  - `valid` = 1 for every stored entry.
- Enqueue:
  - p = length of the leading-ones run in `fetch_valid`.
  - free = `DEPTH` − `entry_count`, using the registered count; slots freed by a same-cycle dequeue are not reusable.
  - `fetch_accept_count` = min(p, free, `WIDTH`), forced to 0 when `squash` is high.
  - Accepted lanes 0..k−1 are written at tail, tail+1, …; tail advances by k mod `DEPTH`.
- Dequeue:
  - d_eff = min(`dispatch_count`, `entry_count`, `WIDTH`).
  - Head advances by d_eff mod `DEPTH`. Excess `dispatch_count` is ignored, with no underflow.
- Count update: next count = count + k − d_eff. Simultaneous enqueue and dequeue is legal, including at full and at empty.
- Outputs:
  - `decode_out[i]` = entry at head+i mod `DEPTH` when `decode_out_valid[i]`.
  - Invalid lanes drive all-zero.
- Squash: on that posedge, head = tail = count = 0. Same-cycle fetch and dispatch are discarded.
- Reset (asynchronous assert): head = tail = count = 0, all storage valid bits = 0. Every output reads 0: `decode_out_valid` = 0, `entry_count` = 0, `decode_out` all-zero, `fetch_accept_count` = 0 while `reset_n` is low. Release is synchronous to `clock` in use.

## Timing
- Enqueue-to-visible latency: 1 cycle. An entry written at edge N appears on `decode_out` after edge N.
- `fetch_accept_count` and `decode_out*` are valid in the same cycle, with no dependence on `dispatch_count`. There is no combinational path from `dispatch_count` to any output.
- Full: `fetch_accept_count` = 0 even if dispatch drains in the same cycle.
- Empty: `decode_out_valid` = 0 and dispatch has no effect.
- Pointers wrap at `DEPTH`. Lane reads wrap across the storage end.

## Configuration
- `DECQ_ILLEGAL_FENCE_EN` defined:
  - Once an entry with `illegal` or `halt` set is enqueued, no younger lane is accepted. Same-cycle younger lanes are cut: k stops after the fencing lane.
  - The fence holds until that entry is dequeued or `squash` fires.
  - `fetch_accept_count` = 0 while fenced.
- Undefined: illegal and halt instructions are queued like any other, and acceptance is limited only by space.

## Test plan
- Reset, then with `WIDTH`=2, `DEPTH`=8: `fetch_valid`=2'b11 carrying ADDI and MUL at PC 0x0/0x4, `dispatch_count`=0 → accept 2. Next cycle `decode_out_valid`=2'b11, lane0 FU=ALU opb=I_IMM, lane1 mult=1 FU=MULT, NPC 0x4/0x8, `entry_count`=2.
- `fetch_valid`=2'b10 → accept 0, no entry written. `fetch_valid`=2'b01 with BEQ → `rs1_used`=`rs2_used`=1, FU=BU.
- Fill to 8 while dispatching 0. At count 8, present 2 lanes with `dispatch_count`=2 → accept 0, count 6 next cycle. Continue 20 cycles of 2-in/2-out → pointers wrap and the output order matches the input order.
- At count 5, assert `squash` together with valid fetch and `dispatch_count`=2 → count 0 next cycle, `decode_out_valid`=0. Assert `reset_n`=0 mid-stream → outputs 0 immediately, without waiting for a clock edge.
- With `DECQ_ILLEGAL_FENCE_EN`: lanes {0x00000000 illegal, ADD} → accept 1, then 0 per cycle until the head is dispatched, then normal acceptance. Without the macro the same stimulus → accept 2.
